// File: rtl/keypad_scanner_fsm.sv
// Matrix keypad scanner: one-hot row drive, per-scan debounce, chord rejection, binary key events.
// Latency: key_valid one clk after the scan end that completes DEBOUNCE_SCANS matching scans.
// Backpressure: none; key_valid / multi_key / key_repeat are one-cycle pulses the consumer must take.
//
// Ports:
//   clk        system clock (row timing uses an internal clock-enable divider, no derived clocks)
//   rst        asynchronous active-low reset
//   COLUMNAS   raw column sense lines, active-high when a key in the driven row is pressed
//   FILAS      one-hot active-high row drive
//   key_code   code of the last accepted key, row*COLS + col (held after release)
//   key_valid  one-cycle pulse when a new key is accepted
//   key_held   high while the accepted key remains pressed (including release debounce)
//   multi_key  one-cycle pulse when a scan shows a chord while no key is held
//   key_repeat one-cycle auto-repeat pulse; only built when KEYPAD_REPEAT_EN is defined, else 0
//
// Optional feature macro: KEYPAD_REPEAT_EN (adds REPEAT_DELAY / REPEAT_RATE, both in scans).
module keypad_scanner_fsm #(
   parameter int ROWS           = 4,
   parameter int COLS           = 4,
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 8,
`ifdef KEYPAD_REPEAT_EN
   parameter int REPEAT_DELAY   = 50,
   parameter int REPEAT_RATE    = 10,
`endif
   localparam int KW            = $clog2(ROWS*COLS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [COLS-1:0] COLUMNAS,
   output logic [ROWS-1:0] FILAS,
   output logic [KW-1:0]   key_code,
   output logic            key_valid,
   output logic            key_held,
   output logic            multi_key,
   output logic            key_repeat
);

   localparam int         NK  = ROWS * COLS;
   localparam int         DW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int         RW  = $clog2(ROWS);
   localparam logic [7:0] DEB = 8'(DEBOUNCE_SCANS);

   typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_PRESSED, S_RELEASE} state_t;

   logic [COLS-1:0] col_s1, col_s2;
   logic [DW-1:0]   div_cnt;
   logic [RW-1:0]   row_idx;
   logic [NK-1:0]   acc, scan_bits;
   logic            row_tick, scan_end;
   logic [7:0]      n_set;
   logic [KW-1:0]   hit_code;
   logic            is_single, is_multi, cand_seen;

   state_t          state, state_nxt;
   logic [KW-1:0]   cand, cand_nxt, key_code_nxt;
   logic [7:0]      dcnt, dcnt_nxt, rcnt, rcnt_nxt;
   logic            key_valid_nxt, key_held_nxt, multi_key_nxt;

   // ---------------------------------------------------------------- row scan
   assign row_tick = (div_cnt == DW'(SCAN_DIV - 1));
   assign scan_end = row_tick && (row_idx == RW'(ROWS - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_s1  <= '0;
         col_s2  <= '0;
         div_cnt <= '0;
         row_idx <= '0;
         FILAS   <= ROWS'(1);
         acc     <= '0;
      end else begin
         col_s1 <= COLUMNAS;
         col_s2 <= col_s1;
         if (row_tick) begin
            div_cnt <= '0;
            // The last row's bits are folded in combinationally at scan end,
            // so the accumulator can start clean for the next scan.
            acc     <= scan_end ? '0 : scan_bits;
            if (row_idx == RW'(ROWS - 1))
               row_idx <= '0;
            else
               row_idx <= row_idx + RW'(1);
            FILAS   <= {FILAS[ROWS-2:0], FILAS[ROWS-1]};
         end else begin
            div_cnt <= div_cnt + DW'(1);
         end
      end
   end

   // Accumulated scan including the row being captured this cycle.
   always_comb begin
      scan_bits = acc;
      for (int r = 0; r < ROWS; r++) begin
         if (row_idx == RW'(r))
            scan_bits[r*COLS +: COLS] = acc[r*COLS +: COLS] | col_s2;
      end
   end

   // Popcount plus index of a set bit; the index is only meaningful when exactly one is set.
   always_comb begin
      n_set    = '0;
      hit_code = '0;
      for (int k = 0; k < NK; k++) begin
         if (scan_bits[k]) begin
            n_set    = n_set + 8'd1;
            hit_code = KW'(k);
         end
      end
   end

   assign is_single = (n_set == 8'd1);
   assign is_multi  = (n_set >  8'd1);
   assign cand_seen = scan_bits[cand];

   // ---------------------------------------------------------------- key FSM
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         cand      <= '0;
         dcnt      <= '0;
         rcnt      <= '0;
         key_code  <= '0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
         multi_key <= 1'b0;
      end else begin
         state     <= state_nxt;
         cand      <= cand_nxt;
         dcnt      <= dcnt_nxt;
         rcnt      <= rcnt_nxt;
         key_code  <= key_code_nxt;
         key_valid <= key_valid_nxt;
         key_held  <= key_held_nxt;
         multi_key <= multi_key_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cand_nxt      = cand;
      dcnt_nxt      = dcnt;
      rcnt_nxt      = rcnt;
      key_code_nxt  = key_code;
      key_held_nxt  = key_held;
      key_valid_nxt = 1'b0;
      multi_key_nxt = 1'b0;
      if (scan_end) begin
         unique case (state)
            S_IDLE: begin
               if (is_single) begin
                  cand_nxt = hit_code;
                  dcnt_nxt = 8'd1;
                  if (DEB == 8'd1) begin
                     state_nxt     = S_PRESSED;
                     key_code_nxt  = hit_code;
                     key_valid_nxt = 1'b1;
                     key_held_nxt  = 1'b1;
                     rcnt_nxt      = '0;
                  end else begin
                     state_nxt = S_DEBOUNCE;
                  end
               end else if (is_multi) begin
                  multi_key_nxt = 1'b1;
               end
            end
            S_DEBOUNCE: begin
               if (is_single) begin
                  if (hit_code == cand) begin
                     if (dcnt + 8'd1 >= DEB) begin
                        state_nxt     = S_PRESSED;
                        key_code_nxt  = cand;
                        key_valid_nxt = 1'b1;
                        key_held_nxt  = 1'b1;
                        rcnt_nxt      = '0;
                     end else begin
                        dcnt_nxt = dcnt + 8'd1;
                     end
                  end else begin
                     cand_nxt = hit_code;
                     dcnt_nxt = 8'd1;
                  end
               end else if (is_multi) begin
                  state_nxt     = S_IDLE;
                  multi_key_nxt = 1'b1;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
            S_PRESSED: begin
               // Only the accepted key matters here; a scan without it counts as a release scan.
               if (cand_seen) begin
                  rcnt_nxt = '0;
               end else if (DEB == 8'd1) begin
                  state_nxt    = S_IDLE;
                  key_held_nxt = 1'b0;
                  rcnt_nxt     = '0;
               end else begin
                  state_nxt = S_RELEASE;
                  rcnt_nxt  = 8'd1;
               end
            end
            S_RELEASE: begin
               if (cand_seen) begin
                  // Bounce on release: resume without a new event.
                  state_nxt = S_PRESSED;
                  rcnt_nxt  = '0;
               end else if (rcnt + 8'd1 >= DEB) begin
                  state_nxt    = S_IDLE;
                  key_held_nxt = 1'b0;
                  rcnt_nxt     = '0;
               end else begin
                  rcnt_nxt = rcnt + 8'd1;
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------- auto-repeat
`ifdef KEYPAD_REPEAT_EN
   logic [15:0] rep_cnt, rep_cnt_nxt, rep_tgt;
   logic        rep_phase, rep_phase_nxt, key_repeat_nxt, stay_pressed;

   // Counts only scans that keep the FSM in PRESSED; any other scan end restarts the delay.
   assign stay_pressed = (state == S_PRESSED) && cand_seen;
   assign rep_tgt      = rep_phase ? 16'(REPEAT_RATE) : 16'(REPEAT_DELAY);

   always_comb begin
      rep_cnt_nxt    = rep_cnt;
      rep_phase_nxt  = rep_phase;
      key_repeat_nxt = 1'b0;
      if (scan_end) begin
         if (stay_pressed) begin
            if (rep_cnt + 16'd1 == rep_tgt) begin
               key_repeat_nxt = 1'b1;
               rep_cnt_nxt    = '0;
               rep_phase_nxt  = 1'b1;
            end else begin
               rep_cnt_nxt = rep_cnt + 16'd1;
            end
         end else begin
            rep_cnt_nxt   = '0;
            rep_phase_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rep_cnt    <= '0;
         rep_phase  <= 1'b0;
         key_repeat <= 1'b0;
      end else begin
         rep_cnt    <= rep_cnt_nxt;
         rep_phase  <= rep_phase_nxt;
         key_repeat <= key_repeat_nxt;
      end
   end
`else
   assign key_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scanner_fsm.sv
// Bench for keypad_scanner_fsm: directed scan table, random scans vs. a scan-level model,
// and hand-written timing cases (press latency, reset mid-press, optional auto-repeat).
module tb_keypad_scanner_fsm;

   localparam int ROWS     = 4;
   localparam int COLS     = 4;
   localparam int SCAN_DIV = 4;
   localparam int DEB      = 3;
   localparam int SCAN_CLK = ROWS * SCAN_DIV;
`ifdef KEYPAD_REPEAT_EN
   localparam int R_DELAY  = 4;
   localparam int R_RATE   = 2;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] keys = '0;
   logic [3:0]  columnas, filas, key_code;
   logic        key_valid, key_held, multi_key, key_repeat;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Physical keypad: a pressed key connects its row drive to its column.
   always_comb begin
      columnas = '0;
      for (int r = 0; r < ROWS; r++)
         if (filas[r]) columnas = columnas | keys[r*COLS +: COLS];
   end

   keypad_scanner_fsm #(
      .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)
`ifdef KEYPAD_REPEAT_EN
      , .REPEAT_DELAY(R_DELAY), .REPEAT_RATE(R_RATE)
`endif
   ) dut (
      .clk(clk), .rst(rst), .COLUMNAS(columnas), .FILAS(filas), .key_code(key_code),
      .key_valid(key_valid), .key_held(key_held), .multi_key(multi_key), .key_repeat(key_repeat)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // ---------------------------------------------------------------- scan-level model
   int m_held, m_cand, m_cnt, m_rel, m_code, m_since;

   task automatic model_reset();
      m_held = 0; m_cand = 0; m_cnt = 0; m_rel = 0; m_code = 0; m_since = 0;
   endtask

   task automatic model_step(input logic [15:0] mask, output int v, output int h,
                             output int m, output int r, output int code);
      int n, idx;
      v = 0; m = 0; r = 0;
      n = $countones(mask);
      idx = 0;
      for (int k = 15; k >= 0; k--) if (mask[k]) idx = k;
      if (m_held == 0) begin
         if (n > 1) begin
            m = 1; m_cnt = 0;
         end else if (n == 0) begin
            m_cnt = 0;
         end else begin
            if (m_cnt > 0 && idx == m_cand) m_cnt++;
            else begin m_cand = idx; m_cnt = 1; end
            if (m_cnt >= DEB) begin
               m_held = 1; v = 1; m_code = m_cand; m_rel = 0; m_since = 0; m_cnt = 0;
            end
         end
      end else begin
         if (mask[m_cand]) begin
            if (m_rel == 0) begin
               m_since++;
`ifdef KEYPAD_REPEAT_EN
               if (m_since >= R_DELAY && (m_since - R_DELAY) % R_RATE == 0) r = 1;
`endif
            end else begin
               m_since = 0;
            end
            m_rel = 0;
         end else begin
            m_rel++; m_since = 0;
            if (m_rel >= DEB) begin m_held = 0; m_cnt = 0; end
         end
      end
      h = m_held; code = m_code;
   endtask

   // ---------------------------------------------------------------- stimulus helpers
   // One full scan with the given keys pressed; outputs sampled #1 after each edge.
   // Pulses belonging to this scan appear on the last sample only.
   task automatic run_scan(input logic [15:0] mask, output int v, output int h, output int m,
                           output int r, output int code, output int extra, output int fbad);
      keys = mask; extra = 0; fbad = 0;
      for (int i = 1; i <= SCAN_CLK; i++) begin
         @(posedge clk); #1;
         if (int'(filas) != (1 << ((i / SCAN_DIV) % ROWS))) fbad++;
         if (i < SCAN_CLK) extra += int'(key_valid) + int'(multi_key) + int'(key_repeat);
      end
      v = int'(key_valid); h = int'(key_held); m = int'(multi_key);
      r = int'(key_repeat); code = int'(key_code);
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_filas", filas, 1);
      check("rst_code", key_code, 0);
      check("rst_valid", key_valid, 0);
      check("rst_held", key_held, 0);
      check("rst_multi", multi_key, 0);
      check("rst_repeat", key_repeat, 0);
      rst = 1'b1;
   endtask

   typedef struct {
      logic [15:0] mask;
      int v; int h; int m; int code;
   } vec_t;

   function automatic vec_t mkv(input logic [15:0] mask, input int v, input int h,
                                input int m, input int code);
      vec_t t;
      t.mask = mask; t.v = v; t.h = h; t.m = m; t.code = code;
      return t;
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[$];
      int v, h, m, r, code, extra, fbad, ev, eh, em, er, ecode;
      int cyc, found, pick;
      logic [15:0] cur;

      // mask, key_valid, key_held, multi_key, key_code (sampled at each scan end)
      // key 0 held through reset, accepted on the third scan, then released
      tbl.push_back(mkv(16'h0001,0,0,0,0)); tbl.push_back(mkv(16'h0001,0,0,0,0));
      tbl.push_back(mkv(16'h0001,1,1,0,0)); tbl.push_back(mkv(16'h0000,0,1,0,0));
      tbl.push_back(mkv(16'h0000,0,1,0,0)); tbl.push_back(mkv(16'h0000,0,0,0,0));
      // key 6 (row 1, col 2)
      tbl.push_back(mkv(16'h0040,0,0,0,0)); tbl.push_back(mkv(16'h0040,0,0,0,0));
      tbl.push_back(mkv(16'h0040,1,1,0,6)); tbl.push_back(mkv(16'h0040,0,1,0,6));
      tbl.push_back(mkv(16'h0000,0,1,0,6)); tbl.push_back(mkv(16'h0000,0,1,0,6));
      tbl.push_back(mkv(16'h0000,0,0,0,6));
      // bounce on key 0: 2 present, 1 absent, 5 present
      tbl.push_back(mkv(16'h0001,0,0,0,6)); tbl.push_back(mkv(16'h0001,0,0,0,6));
      tbl.push_back(mkv(16'h0000,0,0,0,6)); tbl.push_back(mkv(16'h0001,0,0,0,6));
      tbl.push_back(mkv(16'h0001,0,0,0,6)); tbl.push_back(mkv(16'h0001,1,1,0,0));
      tbl.push_back(mkv(16'h0001,0,1,0,0)); tbl.push_back(mkv(16'h0001,0,1,0,0));
      tbl.push_back(mkv(16'h0000,0,1,0,0)); tbl.push_back(mkv(16'h0000,0,1,0,0));
      tbl.push_back(mkv(16'h0000,0,0,0,0));
      // chord on row 3, cols 0 and 1
      tbl.push_back(mkv(16'h3000,0,0,1,0)); tbl.push_back(mkv(16'h3000,0,0,1,0));
      tbl.push_back(mkv(16'h3000,0,0,1,0));
      // key 15 with release bounce
      tbl.push_back(mkv(16'h8000,0,0,0,0)); tbl.push_back(mkv(16'h8000,0,0,0,0));
      tbl.push_back(mkv(16'h8000,1,1,0,15)); tbl.push_back(mkv(16'h0000,0,1,0,15));
      tbl.push_back(mkv(16'h0000,0,1,0,15)); tbl.push_back(mkv(16'h8000,0,1,0,15));
      tbl.push_back(mkv(16'h0000,0,1,0,15)); tbl.push_back(mkv(16'h0000,0,1,0,15));
      tbl.push_back(mkv(16'h0000,0,0,0,15));
      // candidate restart, chord containing the held key, different key while held
      tbl.push_back(mkv(16'h0002,0,0,0,15)); tbl.push_back(mkv(16'h0004,0,0,0,15));
      tbl.push_back(mkv(16'h0004,0,0,0,15)); tbl.push_back(mkv(16'h0004,1,1,0,2));
      tbl.push_back(mkv(16'h0006,0,1,0,2));  tbl.push_back(mkv(16'h0008,0,1,0,2));
      tbl.push_back(mkv(16'h0000,0,1,0,2));  tbl.push_back(mkv(16'h0000,0,0,0,2));
      // chord during debounce aborts it
      tbl.push_back(mkv(16'h0010,0,0,0,2));  tbl.push_back(mkv(16'h0011,0,0,1,2));
      tbl.push_back(mkv(16'h0010,0,0,0,2));  tbl.push_back(mkv(16'h0010,0,0,0,2));
      tbl.push_back(mkv(16'h0010,1,1,0,4));  tbl.push_back(mkv(16'h0000,0,1,0,4));
      tbl.push_back(mkv(16'h0000,0,1,0,4));  tbl.push_back(mkv(16'h0000,0,0,0,4));

      // ---- directed table
      keys = 16'h0001;
      do_reset();
      foreach (tbl[i]) begin
         run_scan(tbl[i].mask, v, h, m, r, code, extra, fbad);
         check($sformatf("tbl%0d_valid", i), v, tbl[i].v);
         check($sformatf("tbl%0d_held", i), h, tbl[i].h);
         check($sformatf("tbl%0d_multi", i), m, tbl[i].m);
         check($sformatf("tbl%0d_code", i), code, tbl[i].code);
         check($sformatf("tbl%0d_repeat", i), r, 0);
         check($sformatf("tbl%0d_stray_pulses", i), extra, 0);
         check($sformatf("tbl%0d_filas_bad", i), fbad, 0);
      end

      // ---- random scans against the model
      keys = '0;
      model_reset();
      do_reset();
      cur = '0;
      for (int s = 0; s < 300; s++) begin
         pick = $urandom_range(0, 99);
         if (pick < 55)      cur = cur;
         else if (pick < 70) cur = '0;
         else if (pick < 88) cur = 16'(1) << $urandom_range(0, 15);
         else                cur = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
         run_scan(cur, v, h, m, r, code, extra, fbad);
         model_step(cur, ev, eh, em, er, ecode);
         check($sformatf("rnd%0d_valid", s), v, ev);
         check($sformatf("rnd%0d_held", s), h, eh);
         check($sformatf("rnd%0d_multi", s), m, em);
         check($sformatf("rnd%0d_repeat", s), r, er);
         check($sformatf("rnd%0d_code", s), code, ecode);
         check($sformatf("rnd%0d_stray_pulses", s), extra, 0);
         check($sformatf("rnd%0d_filas_bad", s), fbad, 0);
      end

      // ---- unaligned press of key 6: event within 4 scans + 3 clk
      keys = '0;
      do_reset();
      for (int s = 0; s < 2; s++) run_scan(16'h0000, v, h, m, r, code, extra, fbad);
      repeat ($urandom_range(0, 15)) @(posedge clk);
      #2 keys = 16'h0040;
      cyc = 0; found = 0;
      while (found == 0 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
         if (key_valid) found = 1;
      end
      check("press_event_seen", found, 1);
      check("press_latency_within_bound", int'(cyc <= 4 * SCAN_CLK + 3), 1);
      check("press_code", key_code, 6);
      check("press_held", key_held, 1);
      cyc = 0;
      for (int i = 0; i < 3 * SCAN_CLK; i++) begin
         @(posedge clk); #1;
         cyc += int'(key_valid);
      end
      check("press_single_event", cyc, 0);
      check("press_still_held", key_held, 1);

      // ---- asynchronous reset while the key is held: no event, must re-debounce
      @(posedge clk); #3 rst = 1'b0; #1;
      check("midrst_filas", filas, 1);
      check("midrst_held", key_held, 0);
      check("midrst_code", key_code, 0);
      check("midrst_valid", key_valid, 0);
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         run_scan(16'h0040, v, h, m, r, code, extra, fbad);
         check($sformatf("midrst_scan%0d_valid", k), v, int'(k == 3));
         check($sformatf("midrst_scan%0d_held", k), h, int'(k == 3));
         check($sformatf("midrst_scan%0d_code", k), code, (k == 3) ? 6 : 0);
         check($sformatf("midrst_scan%0d_stray_pulses", k), extra, 0);
      end

`ifdef KEYPAD_REPEAT_EN
      // ---- auto-repeat on key 9: pulses 4, 6, 8 scans after acceptance
      keys = 16'h0200;
      do_reset();
      for (int k = 1; k <= 3; k++) begin
         run_scan(16'h0200, v, h, m, r, code, extra, fbad);
         check($sformatf("rep_accept%0d_valid", k), v, int'(k == 3));
      end
      for (int k = 1; k <= 9; k++) begin
         run_scan(16'h0200, v, h, m, r, code, extra, fbad);
         check($sformatf("rep_scan%0d_repeat", k), r, int'(k == 4 || k == 6 || k == 8));
         check($sformatf("rep_scan%0d_valid", k), v, 0);
         check($sformatf("rep_scan%0d_code", k), code, 9);
         check($sformatf("rep_scan%0d_stray_pulses", k), extra, 0);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
